// File: rtl/pc_write_ctrl_pkg.sv
// pc_write_ctrl_pkg: shared types for the PC write controller (states, pc_src and exc_cause encodings).
package pc_write_ctrl_pkg;
    typedef enum logic [1:0] {RUN, EXC_RD, EXC_WAIT, EXC_LOAD} state_t;
    typedef enum logic [1:0] {SRC_ALU_RESULT, SRC_ALU_OUT, SRC_JUMP, SRC_EPC} pc_src_t;
    typedef enum logic [1:0] {EXC_BAD_OP, EXC_OVF, EXC_DIV0, EXC_RSVD} exc_cause_t;

    // The reserved cause shares the bad-opcode vector.
    function automatic logic [1:0] vec_offset(input logic [1:0] cause);
        return (cause == EXC_RSVD) ? 2'(EXC_BAD_OP) : cause;
    endfunction
endpackage

// File: rtl/pc_write_ctrl_if.sv
// pc_write_ctrl_if: control, datapath and vector-fetch signals of the PC write controller.
interface pc_write_ctrl_if #(parameter int WIDTH = 32);
    logic             pc_write;
    logic             pc_write_cond;
    logic             flag_in;
    logic [1:0]       pc_src;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] alu_out;
    logic [25:0]      instr_target;
    logic             exc_req;
    logic [1:0]       exc_cause;
    logic [7:0]       mem_rdata;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] epc;
    logic [WIDTH-1:0] vec_addr;
    logic             vec_rd;
    logic             exc_busy;
    logic             pc_we;
    logic             align_err;

    modport master (
        output pc_write, pc_write_cond, flag_in, pc_src, alu_result, alu_out, instr_target,
               exc_req, exc_cause, mem_rdata,
        input  pc, epc, vec_addr, vec_rd, exc_busy, pc_we, align_err
    );

    modport slave (
        input  pc_write, pc_write_cond, flag_in, pc_src, alu_result, alu_out, instr_target,
               exc_req, exc_cause, mem_rdata,
        output pc, epc, vec_addr, vec_rd, exc_busy, pc_we, align_err
    );
endinterface

// File: rtl/pc_write_ctrl_exc_seq.sv
// pc_write_ctrl_exc_seq: exception entry FSM, RUN -> EXC_RD -> EXC_WAIT -> EXC_LOAD, with memory latency counter.
module pc_write_ctrl_exc_seq
    import pc_write_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic vec_rd,
    output logic exc_busy,
    output logic load
);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

    state_t        state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            cnt      <= '0;
            vec_rd   <= 1'b0;
            exc_busy <= 1'b0;
            load     <= 1'b0;
        end else begin
            vec_rd <= 1'b0;
            load   <= 1'b0;
            case (state)
                RUN: if (start) begin
                    state    <= EXC_RD;
                    vec_rd   <= 1'b1;
                    exc_busy <= 1'b1;
                end
                EXC_RD: begin
                    cnt   <= CNT_INIT;
                    state <= (MEM_LAT == 1) ? EXC_LOAD : EXC_WAIT;
                    load  <= (MEM_LAT == 1);
                end
                EXC_WAIT: if (cnt == '0) begin
                    state <= EXC_LOAD;
                    load  <= 1'b1;
                end else begin
                    cnt <= cnt - CW'(1);
                end
                EXC_LOAD: begin
                    state    <= RUN;
                    exc_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/pc_write_ctrl.sv
// pc_write_ctrl: PC/EPC registers, next-PC mux, write enable and exception entry sequencing.
// Optional misaligned-target suppression with align_err pulse when PC_ALIGN_CHECK_EN is defined.
module pc_write_ctrl
    import pc_write_ctrl_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int VEC_BASE = 253,
    parameter int MEM_LAT  = 1
) (
    input  logic             clk,
    input  logic             reset,
    pc_write_ctrl_if.slave   bus
);
    logic             start;
    logic             load;
    logic             vec_rd;
    logic             exc_busy;
    logic             wr;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] epc;
    logic [WIDTH-1:0] vec_addr;
    logic [WIDTH-1:0] next_pc;

    assign start     = ~exc_busy & bus.exc_req;
    assign bus.pc_we = ~exc_busy & ~bus.exc_req & (bus.pc_write | (bus.pc_write_cond & bus.flag_in));

    always_comb begin
        next_pc = (bus.pc_src == SRC_ALU_RESULT) ? bus.alu_result :
                  (bus.pc_src == SRC_ALU_OUT)    ? bus.alu_out :
                  (bus.pc_src == SRC_JUMP)       ? {pc[WIDTH-1:28], bus.instr_target, 2'b00} :
                                                   epc;
    end

`ifdef PC_ALIGN_CHECK_EN
    assign bus.align_err = bus.pc_we & (next_pc[1:0] != 2'b00);
`else
    assign bus.align_err = 1'b0;
`endif
    assign wr = bus.pc_we & ~bus.align_err;

    pc_write_ctrl_exc_seq #(.MEM_LAT(MEM_LAT)) u_exc_seq (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .vec_rd   (vec_rd),
        .exc_busy (exc_busy),
        .load     (load)
    );

    // load and wr never coincide: wr needs RUN, load only occurs in EXC_LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= '0;
            epc      <= '0;
            vec_addr <= '0;
        end else begin
            if (start) begin
                epc      <= pc - WIDTH'(4);
                vec_addr <= WIDTH'(VEC_BASE) + WIDTH'(vec_offset(bus.exc_cause));
            end
            if (load)
                pc <= WIDTH'(bus.mem_rdata);
            else if (wr)
                pc <= next_pc;
        end
    end

    assign bus.pc       = pc;
    assign bus.epc      = epc;
    assign bus.vec_addr = vec_addr;
    assign bus.vec_rd   = vec_rd;
    assign bus.exc_busy = exc_busy;
endmodule
